bayer_mosaic: RTL

//  Converts a raster RGB pixel stream back into a single-channel Bayer raw stream
//  (the inverse of demosaic_neighbor). Used to regenerate sensor-format frames

---
 rtl/bayer_mosaic.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bayer_mosaic.sv
// Re-mosaics a raster RGB stream into a single-channel Bayer raw stream.
// A 2-entry output buffer gives valid/ready flow control on both sides.
module bayer_mosaic #(
  parameter int width   = 320,
  parameter int height  = 240,
  parameter int PATTERN = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  input  logic       iValid,
  output logic       oReady,
  output logic [7:0] oData,
  output logic       oValid,
  input  logic       iReady,
  output logic       oSof,
  output logic       oDone
);

  localparam int XW = (width  > 1) ? $clog2(width)  : 1;
  localparam int YW = (height > 1) ? $clog2(height) : 1;
  localparam logic [XW-1:0] XLAST = XW'(width - 1);
  localparam logic [YW-1:0] YLAST = YW'(height - 1);

  localparam logic [1:0] SEL_R = 2'd0;
  localparam logic [1:0] SEL_G = 2'd1;
  localparam logic [1:0] SEL_B = 2'd2;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    count;
  logic [9:0]    head;
  logic [9:0]    tail;
  logic [1:0]    parity;
  logic [1:0]    sel;
  logic [7:0]    sample;
  logic [9:0]    entry;
  logic          accept;
  logic          pop;

  assign oReady = (count < 2'd2);
  assign oValid = (count != 2'd0);
  assign {oSof, oDone, oData} = head;

  assign accept = iValid && oReady;
  assign pop    = oValid && iReady;
  assign parity = {y[0], x[0]};

  // CFA phase decides which channel each 2x2 site keeps
  always_comb begin
    sel = SEL_G;
    case (PATTERN)
      1: begin
        if (parity == 2'b01)      sel = SEL_R;
        else if (parity == 2'b10) sel = SEL_B;
      end
      2: begin
        if (parity == 2'b01)      sel = SEL_B;
        else if (parity == 2'b10) sel = SEL_R;
      end
      3: begin
        if (parity == 2'b00)      sel = SEL_B;
        else if (parity == 2'b11) sel = SEL_R;
      end
      default: begin
        if (parity == 2'b00)      sel = SEL_R;
        else if (parity == 2'b11) sel = SEL_B;
      end
    endcase
  end

  always_comb begin
    sample = iG;
    if (sel == SEL_R)      sample = iR;
    else if (sel == SEL_B) sample = iB;
  end

  assign entry = {(x == '0) && (y == '0), (x == XLAST) && (y == YLAST), sample};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (x == XLAST) begin
        x <= '0;
        y <= (y == YLAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // head drives the outputs directly, so it keeps its value while empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (accept) begin
            head  <= entry;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (accept && pop) begin
            head <= entry;
          end else if (accept) begin
            tail  <= entry;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head  <= tail;
            count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule
